operand_loader: RTL

//  Front-end stage feeding the 5-bit signed magnitude comparator. Captures two
//  two's-complement operands A and B from slide switches using one load button.
//  The button is synchronized and debounced, and an FSM sequences the A/B entry.
//  A, B and VALID drive the comparator and display path directly.

---
 rtl/operand_loader.sv | 130 +++++++++++++
 1 files changed

// File: rtl/operand_loader.sv
// operand_loader: captures two signed operands from the slide switches with a
// single load button. BTN is synchronized, debounced and edge-detected into a
// one-cycle load strobe, and a small FSM steps through A entry, B entry and
// result display.
module operand_loader #(
  parameter int WIDTH    = 5,
  parameter int DB_COUNT = 500000
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] SW,
  input  logic             BTN,
  output logic [WIDTH-1:0] A,
  output logic [WIDTH-1:0] B,
  output logic             VALID,
  output logic [1:0]       STATE
);

  localparam int CW = (DB_COUNT > 1) ? $clog2(DB_COUNT) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DB_COUNT - 1);

  typedef enum logic [1:0] {
    WAIT_A = 2'b00,
    WAIT_B = 2'b01,
    SHOW   = 2'b10
  } state_t;

  // Button front end
  logic          s1_q, s1_d;
  logic          s2_q, s2_d;
  logic          db_q, db_d;
  logic          db_dly_q, db_dly_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ld;

  // Operand FSM
  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             valid_q, valid_d;

  // Synchronizer, debouncer and edge-detect next-state logic
  always_comb begin
    s1_d     = BTN;
    s2_d     = s1_q;
    db_dly_d = db_q;
    db_d     = db_q;
    cnt_d    = '0;
    if (s2_q != db_q) begin
      // Accept the new level only after DB_COUNT consecutive differing cycles;
      // any agreeing cycle restarts the count, so the counter cannot wrap.
      if (cnt_q == CNT_MAX) begin
        db_d = ~db_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  // One-cycle load strobe on each accepted press; release is ignored
  assign ld = db_q & ~db_dly_q;

  // Button front-end registers
  always_ff @(posedge CLK) begin
    if (RST) begin
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      db_q     <= 1'b0;
      db_dly_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      s1_q     <= s1_d;
      s2_q     <= s2_d;
      db_q     <= db_d;
      db_dly_q <= db_dly_d;
      cnt_q    <= cnt_d;
    end
  end

  // Entry sequencing: every transition and capture is qualified by the load strobe
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    valid_d = valid_q;
    if (ld) begin
      case (state_q)
        WAIT_A: begin
          a_d     = SW;
          state_d = WAIT_B;
        end
        WAIT_B: begin
          b_d     = SW;
          valid_d = 1'b1;
          state_d = SHOW;
        end
        SHOW: begin
          // B is kept until recaptured; only VALID signals it is stale
          a_d     = SW;
          valid_d = 1'b0;
          state_d = WAIT_B;
        end
        default: begin
          state_d = WAIT_A;
        end
      endcase
    end
  end

  // Operand and state registers; reset wins over a coincident load
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= WAIT_A;
      a_q     <= '0;
      b_q     <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      valid_q <= valid_d;
    end
  end

  assign A     = a_q;
  assign B     = b_q;
  assign VALID = valid_q;
  assign STATE = state_q;

endmodule
